// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad entry block.
package keypad_pkg;

    localparam int unsigned CODE_W    = 4;
    localparam int unsigned NUM_LINES = 4;
    localparam logic [NUM_LINES-1:0] IDLE_COL = 4'b1110;

    typedef enum logic [1:0] {
        IDLE,
        DEB_PRESS,
        HELD,
        DEB_RELEASE
    } key_state_e;

endpackage

// File: rtl/keypad_col_scanner.sv
// Column scan driver: slot divider, one-hot active-low column drive,
// 2-flop row synchronizer and a visit strobe on the last cycle of each slot.
module keypad_col_scanner
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 50000
) (
    input  logic                 iCLK,
    input  logic                 iReset,
    input  logic [NUM_LINES-1:0] iRow,
    output logic [NUM_LINES-1:0] col_n,
    output logic                 visit,
    output logic [1:0]           visit_col,
    output logic [NUM_LINES-1:0] rows
);

    localparam int unsigned DIV_W = $clog2(SCAN_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

    logic [DIV_W-1:0]     div_q, div_d;
    logic [1:0]           col_q, col_d;
    logic [NUM_LINES-1:0] col_n_q, col_n_d;
    logic [NUM_LINES-1:0] sync1_q, sync1_d;
    logic [NUM_LINES-1:0] sync2_q, sync2_d;
    logic                 slot_end;

    always_comb begin
        slot_end = (div_q == DIV_LAST);
        div_d    = slot_end ? '0 : div_q + DIV_W'(1);
        col_d    = slot_end ? col_q + 2'd1 : col_q;
        // rotating the drive pattern keeps it one-hot without a decoder
        col_n_d  = slot_end ? {col_n_q[NUM_LINES-2:0], col_n_q[NUM_LINES-1]} : col_n_q;
        sync1_d  = iRow;
        sync2_d  = sync1_q;
    end

    always_ff @(posedge iCLK or posedge iReset) begin
        if (iReset) begin
            div_q   <= '0;
            col_q   <= '0;
            col_n_q <= IDLE_COL;
            sync1_q <= '1;
            sync2_q <= '1;
        end else begin
            div_q   <= div_d;
            col_q   <= col_d;
            col_n_q <= col_n_d;
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign col_n     = col_n_q;
    assign visit     = slot_end;
    assign visit_col = col_q;
    assign rows      = sync2_q;

endmodule

// File: rtl/keypad_entry.sv
// 4x4 keypad entry: debounced key capture into a two-digit hex register.
// Define KEYPAD_AUTOREPEAT_EN to re-emit a held key every REPEAT_SCANS scan periods.
module keypad_entry
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_DIV       = 50000,
    parameter int unsigned DEBOUNCE_SCANS = 4,
    parameter int unsigned REPEAT_SCANS   = 40
) (
    input  logic                 iCLK,
    input  logic                 iReset,
    input  logic [NUM_LINES-1:0] iRow,
    output logic [NUM_LINES-1:0] oCol,
    output logic [CODE_W-1:0]    oKey,
    output logic                 oKeyValid,
    output logic [2*CODE_W-1:0]  oHex
);

    if (SCAN_DIV < 2 || SCAN_DIV > (1 << 20)) begin : g_bad_scan_div
        $error("keypad_entry: SCAN_DIV out of range");
    end
    if (DEBOUNCE_SCANS < 1 || DEBOUNCE_SCANS > 15) begin : g_bad_debounce
        $error("keypad_entry: DEBOUNCE_SCANS out of range");
    end
    if (REPEAT_SCANS < 1) begin : g_bad_repeat
        $error("keypad_entry: REPEAT_SCANS out of range");
    end

    localparam logic [3:0] DEB_LAST = 4'(DEBOUNCE_SCANS);

    logic                 visit;
    logic [1:0]           visit_col;
    logic [NUM_LINES-1:0] rows;

    keypad_col_scanner #(
        .SCAN_DIV(SCAN_DIV)
    ) u_scan (
        .iCLK      (iCLK),
        .iReset    (iReset),
        .iRow      (iRow),
        .col_n     (oCol),
        .visit     (visit),
        .visit_col (visit_col),
        .rows      (rows)
    );

    key_state_e           state_q, state_d;
    logic [CODE_W-1:0]    cand_q, cand_d;
    logic [3:0]           cnt_q, cnt_d;
    logic [CODE_W-1:0]    key_q, key_d;
    logic                 valid_q, valid_d;
    logic [2*CODE_W-1:0]  hex_q, hex_d;

    logic                 emit;
    logic                 any_down;
    logic [1:0]           hit_row;
    logic                 cand_seen;
    logic                 cand_down;
    logic [3:0]           cnt_inc;

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int unsigned REP_W = $clog2(REPEAT_SCANS + 1);
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_SCANS);
    logic [REP_W-1:0] rep_q, rep_d;
`endif

    always_comb begin
        any_down = 1'b0;
        hit_row  = '0;
        for (int unsigned r = 0; r < NUM_LINES; r++) begin
            if (!rows[r] && !any_down) begin
                any_down = 1'b1;
                hit_row  = 2'(r);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        cand_d    = cand_q;
        cnt_d     = cnt_q;
        key_d     = key_q;
        valid_d   = 1'b0;
        hex_d     = hex_q;
        emit      = 1'b0;
        cand_seen = visit && (visit_col == cand_q[1:0]);
        cand_down = !rows[cand_q[3:2]];
        cnt_inc   = cnt_q + 4'd1;
`ifdef KEYPAD_AUTOREPEAT_EN
        rep_d     = rep_q;
`endif

        case (state_q)
            IDLE: begin
                if (visit && any_down) begin
                    cand_d = {hit_row, visit_col};
                    if (DEB_LAST == 4'd1) begin
                        state_d = HELD;
                        cnt_d   = '0;
                        emit    = 1'b1;
                    end else begin
                        state_d = DEB_PRESS;
                        cnt_d   = 4'd1;
                    end
                end
            end
            DEB_PRESS: begin
                if (cand_seen) begin
                    if (!cand_down) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else if (cnt_inc == DEB_LAST) begin
                        state_d = HELD;
                        cnt_d   = '0;
                        emit    = 1'b1;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            HELD: begin
                if (cand_seen) begin
                    if (!cand_down) begin
                        state_d = (DEB_LAST == 4'd1) ? IDLE : DEB_RELEASE;
                        cnt_d   = (DEB_LAST == 4'd1) ? 4'd0 : 4'd1;
                    end else begin
`ifdef KEYPAD_AUTOREPEAT_EN
                        if (rep_q + REP_W'(1) == REP_LAST) begin
                            rep_d = '0;
                            emit  = 1'b1;
                        end else begin
                            rep_d = rep_q + REP_W'(1);
                        end
`endif
                    end
                end
            end
            DEB_RELEASE: begin
                if (cand_seen) begin
                    if (cand_down) begin
                        state_d = HELD;
                        cnt_d   = '0;
                    end else if (cnt_inc == DEB_LAST) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        if (emit) begin
            key_d   = cand_d;
            valid_d = 1'b1;
            hex_d   = {hex_q[CODE_W-1:0], cand_d};
`ifdef KEYPAD_AUTOREPEAT_EN
            // a fresh acceptance restarts the repeat interval
            if (state_q != HELD) rep_d = '0;
`endif
        end
    end

    always_ff @(posedge iCLK or posedge iReset) begin
        if (iReset) begin
            state_q <= IDLE;
            cand_q  <= '0;
            cnt_q   <= '0;
            key_q   <= '0;
            valid_q <= 1'b0;
            hex_q   <= '0;
        end else begin
            state_q <= state_d;
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
            key_q   <= key_d;
            valid_q <= valid_d;
            hex_q   <= hex_d;
        end
    end

`ifdef KEYPAD_AUTOREPEAT_EN
    always_ff @(posedge iCLK or posedge iReset) begin
        if (iReset) rep_q <= '0;
        else        rep_q <= rep_d;
    end
`endif

    assign oKey      = key_q;
    assign oKeyValid = valid_q;
    assign oHex      = hex_q;

endmodule

// File: tb/tb_keypad_entry.sv
// Self-checking bench for keypad_entry with a behavioural keypad and reference model.
module tb_keypad_entry;
    import keypad_pkg::*;

    localparam int unsigned SD   = 4;
    localparam int unsigned DB   = 3;
    localparam int unsigned RS   = 5;
    localparam int unsigned SCAN = 4 * SD;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [3:0]  key;
    logic        valid;
    logic [7:0]  hex;
    logic [15:0] keys;

    int checks = 0;
    int errors = 0;
    int pulses = 0;

    always #5 clk = ~clk;

    // physical keypad: a pressed key pulls its row low while its column is driven
    always_comb begin
        row = '1;
        for (int r = 0; r < 4; r++) row[r] = ~|(keys[4*r +: 4] & ~col);
    end

    keypad_entry #(
        .SCAN_DIV       (SD),
        .DEBOUNCE_SCANS (DB),
        .REPEAT_SCANS   (RS)
    ) dut (
        .iCLK      (clk),
        .iReset    (rst),
        .iRow      (row),
        .oCol      (col),
        .oKey      (key),
        .oKeyValid (valid),
        .oHex      (hex)
    );

    // Reference model: level-change debouncer on per-visit samples of the candidate.
    int         m_cyc, m_cand, m_streak, m_rep, mc;
    bit         m_acc, memit, mp;
    logic [3:0] m_d1, m_d2, mpat, m_key, m_col;
    logic [7:0] m_hex;
    logic       m_valid;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cyc = 0; m_d1 = '1; m_d2 = '1; m_cand = -1; m_acc = 0;
            m_streak = 0; m_rep = 0; m_valid = 0; m_key = '0; m_hex = '0;
            m_col = 4'b1110;
        end else begin
            mc    = (m_cyc / SD) % 4;
            memit = 0;
            for (int r = 0; r < 4; r++) mpat[r] = !keys[4*r + mc];
            if (m_cyc % SD == SD - 1) begin
                if (m_cand < 0) begin
                    for (int r = 0; r < 4; r++) if (!m_d2[r] && m_cand < 0) m_cand = 4*r + mc;
                    if (m_cand >= 0) begin
                        m_acc = 0; m_streak = 1;
                        if (m_streak >= DB) begin m_acc = 1; m_streak = 0; memit = 1; m_rep = 0; end
                    end
                end else if (m_cand % 4 == mc) begin
                    mp = !m_d2[m_cand / 4];
                    if (mp != m_acc) begin
                        m_streak++;
                        if (m_streak >= DB) begin
                            if (!m_acc) begin m_acc = 1; m_streak = 0; memit = 1; m_rep = 0; end
                            else m_cand = -1;
                        end
                    end else if (!m_acc) begin
                        m_cand = -1;
                    end else begin
`ifdef KEYPAD_AUTOREPEAT_EN
                        if (m_streak == 0) begin
                            m_rep++;
                            if (m_rep == RS) begin memit = 1; m_rep = 0; end
                        end
`endif
                        m_streak = 0;
                    end
                end
            end
            m_valid = memit;
            if (memit) begin
                m_key = m_cand[3:0];
                m_hex = {m_hex[3:0], m_cand[3:0]};
            end
            m_d2 = m_d1;
            m_d1 = mpat;
            m_cyc++;
            m_col = ~(4'b0001 << ((m_cyc / SD) % 4));
        end
    end

    task automatic test_reset();
        rst = 1'b1; keys = '0;
        repeat (3) @(negedge clk);
        checks++; if (col !== 4'b1110) begin errors++; $display("FAIL reset_col got=%b want=1110", col); end
        checks++; if (key !== 4'h0) begin errors++; $display("FAIL reset_key got=%h want=0", key); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b want=0", valid); end
        checks++; if (hex !== 8'h00) begin errors++; $display("FAIL reset_hex got=%h want=00", hex); end
        checks++; if (dut.state_q !== IDLE) begin errors++; $display("FAIL reset_state got=%0d want=IDLE", dut.state_q); end
        rst = 1'b0;
    endtask

    task automatic test_single_key();
        keys = 16'h0040; pulses = 0;
        repeat (10 * SCAN) begin
            @(negedge clk);
            checks++;
            if (valid !== m_valid || col !== m_col || key !== m_key || hex !== m_hex) begin
                errors++;
                $display("FAIL single_key t=%0t got v=%b k=%h h=%h c=%b want v=%b k=%h h=%h c=%b",
                         $time, valid, key, hex, col, m_valid, m_key, m_hex, m_col);
            end
            if (valid) pulses++;
        end
        checks++; if (pulses != 1) begin errors++; $display("FAIL single_pulses got=%0d want=1", pulses); end
        checks++; if (key !== 4'h6) begin errors++; $display("FAIL single_code got=%h want=6", key); end
        checks++; if (hex !== 8'h06) begin errors++; $display("FAIL single_hex got=%h want=06", hex); end
    endtask

    task automatic test_sequence();
        pulses = 0;
        for (int step = 0; step < 4; step++) begin
            case (step)
                0: keys = '0;
                1: keys = 16'h0400;
                2: keys = '0;
                default: keys = 16'h8000;
            endcase
            repeat (((step % 2) ? 6 : 4) * SCAN) begin
                @(negedge clk);
                checks++;
                if (valid !== m_valid || col !== m_col || key !== m_key || hex !== m_hex) begin
                    errors++;
                    $display("FAIL sequence t=%0t got v=%b k=%h h=%h c=%b want v=%b k=%h h=%h c=%b",
                             $time, valid, key, hex, col, m_valid, m_key, m_hex, m_col);
                end
                if (valid) pulses++;
            end
            if (step == 1) begin
                checks++; if (key !== 4'hA) begin errors++; $display("FAIL seq_code got=%h want=a", key); end
                checks++; if (hex !== 8'h6A) begin errors++; $display("FAIL seq_hex1 got=%h want=6a", hex); end
            end
        end
        checks++; if (hex !== 8'hAF) begin errors++; $display("FAIL seq_hex2 got=%h want=af", hex); end
        checks++; if (pulses != 2) begin errors++; $display("FAIL seq_pulses got=%0d want=2", pulses); end
    endtask

    task automatic test_short_press();
        pulses = 0;
        for (int step = 0; step < 3; step++) begin
            keys = (step == 1) ? 16'h0001 : 16'h0000;
            repeat (((step == 1) ? 2 : 4) * SCAN) begin
                @(negedge clk);
                checks++;
                if (valid !== m_valid || col !== m_col || key !== m_key || hex !== m_hex) begin
                    errors++;
                    $display("FAIL short_press t=%0t got v=%b k=%h h=%h c=%b want v=%b k=%h h=%h c=%b",
                             $time, valid, key, hex, col, m_valid, m_key, m_hex, m_col);
                end
                if (valid && step > 0) pulses++;
            end
        end
        checks++; if (pulses != 0) begin errors++; $display("FAIL short_pulses got=%0d want=0", pulses); end
        checks++; if (dut.state_q !== IDLE) begin errors++; $display("FAIL short_state got=%0d want=IDLE", dut.state_q); end
    endtask

    task automatic test_two_keys();
        pulses = 0;
        for (int step = 0; step < 3; step++) begin
            case (step)
                0: keys = 16'h0002;
                1: keys = 16'h2002;
                default: keys = 16'h2000;
            endcase
            repeat (((step == 2) ? 8 : 6) * SCAN) begin
                @(negedge clk);
                checks++;
                if (valid !== m_valid || col !== m_col || key !== m_key || hex !== m_hex) begin
                    errors++;
                    $display("FAIL two_keys t=%0t got v=%b k=%h h=%h c=%b want v=%b k=%h h=%h c=%b",
                             $time, valid, key, hex, col, m_valid, m_key, m_hex, m_col);
                end
                if (valid) pulses++;
            end
            if (step == 1) begin
                checks++; if (pulses != 1 || key !== 4'h1) begin
                    errors++; $display("FAIL two_first got pulses=%0d key=%h want pulses=1 key=1", pulses, key);
                end
            end
        end
        checks++; if (pulses != 2 || key !== 4'hD) begin
            errors++; $display("FAIL two_second got pulses=%0d key=%h want pulses=2 key=d", pulses, key);
        end
        keys = '0;
        repeat (4 * SCAN) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        keys = 16'h0020;
        for (int i = 0; i < 3 * SCAN && dut.state_q != DEB_PRESS; i++) @(negedge clk);
        checks++; if (dut.state_q !== DEB_PRESS) begin errors++; $display("FAIL mid_reach got=%0d want=DEB_PRESS", dut.state_q); end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (hex !== 8'h00) begin errors++; $display("FAIL mid_hex got=%h want=00", hex); end
        checks++; if (col !== 4'b1110) begin errors++; $display("FAIL mid_col got=%b want=1110", col); end
        rst = 1'b0; pulses = 0;
        repeat (5 * SCAN) begin
            @(negedge clk);
            checks++;
            if (valid !== m_valid || col !== m_col || key !== m_key || hex !== m_hex) begin
                errors++;
                $display("FAIL reset_mid t=%0t got v=%b k=%h h=%h c=%b want v=%b k=%h h=%h c=%b",
                         $time, valid, key, hex, col, m_valid, m_key, m_hex, m_col);
            end
            if (valid) pulses++;
        end
        checks++; if (pulses != 1 || key !== 4'h5) begin
            errors++; $display("FAIL mid_accept got pulses=%0d key=%h want pulses=1 key=5", pulses, key);
        end
        keys = '0;
        repeat (4 * SCAN) @(negedge clk);
    endtask

    task automatic test_autorepeat();
        keys = 16'h0008; pulses = 0;
        repeat (14 * SCAN) begin
            @(negedge clk);
            checks++;
            if (valid !== m_valid || col !== m_col || key !== m_key || hex !== m_hex) begin
                errors++;
                $display("FAIL autorepeat t=%0t got v=%b k=%h h=%h c=%b want v=%b k=%h h=%h c=%b",
                         $time, valid, key, hex, col, m_valid, m_key, m_hex, m_col);
            end
            if (valid) begin
                pulses++;
                checks++; if (key !== 4'h3) begin errors++; $display("FAIL rep_code got=%h want=3", key); end
            end
        end
`ifdef KEYPAD_AUTOREPEAT_EN
        checks++; if (pulses != 3) begin errors++; $display("FAIL rep_pulses got=%0d want=3", pulses); end
        checks++; if (hex !== 8'h33) begin errors++; $display("FAIL rep_hex got=%h want=33", hex); end
`else
        checks++; if (pulses != 1) begin errors++; $display("FAIL rep_pulses got=%0d want=1", pulses); end
`endif
        keys = '0;
        repeat (4 * SCAN) @(negedge clk);
    endtask

    task automatic test_random();
        for (int n = 0; n < 24; n++) begin
            keys = '0;
            if ($urandom_range(0, 3) != 0) keys[$urandom_range(0, 15)] = 1'b1;
            if ($urandom_range(0, 3) == 0) keys[$urandom_range(0, 15)] = 1'b1;
            repeat ($urandom_range(1, 6 * SCAN)) begin
                @(negedge clk);
                checks++;
                if (valid !== m_valid || col !== m_col || key !== m_key || hex !== m_hex) begin
                    errors++;
                    $display("FAIL random t=%0t got v=%b k=%h h=%h c=%b want v=%b k=%h h=%h c=%b",
                             $time, valid, key, hex, col, m_valid, m_key, m_hex, m_col);
                end
            end
        end
    endtask

    initial begin
        keys = '0;
        rst  = 1'b1;
        test_reset();
        test_single_key();
        test_sequence();
        test_short_press();
        test_two_keys();
        test_reset_mid();
        test_autorepeat();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
